// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared FSM encoding, bus width default and pointer-width helper
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } arb_state_t;

  localparam int ARB_REQ_WIDTH = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/arb_job_fifo.sv
// rtl/arb_job_fifo.sv - DEPTH x WIDTH synchronous job FIFO with full/empty flags
module arb_job_fifo
  import arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/arb_req_agent.sv
// rtl/arb_req_agent.sv - requester agent: job queue, req/gnt handshake, beat issue
// Optional grant-wait watchdog enabled by defining GNT_TIMEOUT_EN.
module arb_req_agent
  import arb_pkg::*;
#(
  parameter int REQ_WIDTH = ARB_REQ_WIDTH,
  parameter int AGENT_ID  = 0,
  parameter int LEN_WIDTH = 4,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [LEN_WIDTH-1:0] job_len,
  output logic [REQ_WIDTH-1:0] req,
  input  logic [REQ_WIDTH-1:0] gnt,
  output logic                 beat_valid,
  output logic [LEN_WIDTH-1:0] beat_idx,
  output logic                 done,
  output logic                 busy,
  output logic                 timeout
);

  arb_state_t           state;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic [LEN_WIDTH-1:0] head_len;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 my_gnt;
  logic                 last_beat;
  logic                 wait_hit;
  logic                 unused_gnt;

  arb_job_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(LEN_WIDTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (job_valid),
    .wdata(job_len),
    .pop  (pop),
    .rdata(head_len),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Only our own grant bit matters; the rest of the bus belongs to other agents.
  assign my_gnt     = gnt[AGENT_ID];
  assign unused_gnt = ^gnt;

  assign pop        = (state == ST_IDLE) && !fifo_empty;
  assign job_ready  = !fifo_full;
  assign busy       = (state != ST_IDLE) || !fifo_empty;
  assign last_beat  = (beat_cnt == len_q);
  assign beat_valid = (state == ST_XFER) && my_gnt;
  assign beat_idx   = beat_cnt;
  assign done       = beat_valid && last_beat;

  always_comb begin
    req           = '0;
    req[AGENT_ID] = (state != ST_IDLE);
  end

`ifdef GNT_TIMEOUT_EN
  localparam int WW = clog2(TIMEOUT + 1);

  logic [WW-1:0] wait_cnt;
  logic          timeout_q;

  assign wait_hit = (state == ST_REQ) && !my_gnt && (wait_cnt == WW'(TIMEOUT - 1));
  assign timeout  = timeout_q;

  // Counter is zero outside REQ, so every REQ entry starts a fresh wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wait_hit;
      if ((state == ST_REQ) && !my_gnt) wait_cnt <= wait_cnt + 1'b1;
      else                              wait_cnt <= '0;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;

  assign wait_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state    <= ST_REQ;
            len_q    <= head_len;
            beat_cnt <= '0;
          end
        end
        ST_REQ: begin
          if (my_gnt)        state <= ST_XFER;
          else if (wait_hit) state <= ST_IDLE;
        end
        ST_XFER: begin
          // A dropped grant stalls the burst in place; req stays high.
          if (my_gnt) begin
            if (last_beat) state    <= ST_IDLE;
            else           beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
